// File: rtl/rab_inv_pkg.sv
// rab_inv_pkg: shared FSM state type and width helpers for the RAB range-invalidation engine.
// L2 sweep support is selected by the RAB_INV_L2_EN macro.
package rab_inv_pkg;
`ifdef RAB_INV_L2_EN
    localparam bit L2_EN = 1'b1;
`else
    localparam bit L2_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, L1, L2_RD, L2_CHK, DONE} state_e;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int n_slices, input int n_l2);
        return $clog2(n_slices + (L2_EN ? n_l2 : 0) + 1);
    endfunction
endpackage

// File: rtl/rab_inv_engine_if.sv
// rab_inv_engine_if: request, L1 slice and L2 TLB signals of the invalidation engine.
// The count width follows RAB_INV_L2_EN through rab_inv_pkg::cnt_w.
interface rab_inv_engine_if #(
    parameter int AW = 32,
    parameter int N_SLICES = 32,
    parameter int L2_N_SETS = 32,
    parameter int L2_N_SET_ENTRIES = 32,
    parameter int PG_W = 12
) ();
    localparam int VA_TAG_W = AW - PG_W;
    localparam int L2_AW = rab_inv_pkg::idx_w(L2_N_SETS * L2_N_SET_ENTRIES);
    localparam int CNT_W = rab_inv_pkg::cnt_w(N_SLICES, L2_N_SETS * L2_N_SET_ENTRIES);
    logic ReqValid_SI;
    logic ReqReady_SO;
    logic [AW-1:0] ReqVaStart_DI;
    logic [AW-1:0] ReqVaEnd_DI;
    logic [N_SLICES-1:0][AW-1:0] SliceFirst_DI;
    logic [N_SLICES-1:0][AW-1:0] SliceLast_DI;
    logic [N_SLICES-1:0] SliceEn_DI;
    logic [N_SLICES-1:0] SliceInv_SO;
    logic [L2_AW-1:0] L2Addr_DO;
    logic L2Rd_SO;
    logic [VA_TAG_W-1:0] L2RdTag_DI;
    logic L2RdValid_DI;
    logic L2Clr_SO;
    logic Busy_SO;
    logic CfgLock_SO;
    logic Done_SO;
    logic [CNT_W-1:0] InvCnt_DO;
    modport master (
        output ReqValid_SI, ReqVaStart_DI, ReqVaEnd_DI, SliceFirst_DI, SliceLast_DI, SliceEn_DI,
               L2RdTag_DI, L2RdValid_DI,
        input  ReqReady_SO, SliceInv_SO, L2Addr_DO, L2Rd_SO, L2Clr_SO, Busy_SO, CfgLock_SO,
               Done_SO, InvCnt_DO
    );
    modport slave (
        input  ReqValid_SI, ReqVaStart_DI, ReqVaEnd_DI, SliceFirst_DI, SliceLast_DI, SliceEn_DI,
               L2RdTag_DI, L2RdValid_DI,
        output ReqReady_SO, SliceInv_SO, L2Addr_DO, L2Rd_SO, L2Clr_SO, Busy_SO, CfgLock_SO,
               Done_SO, InvCnt_DO
    );
endinterface

// File: rtl/rab_inv_range_cmp.sv
// rab_inv_range_cmp: unsigned overlap test of [lo, hi] against the latched request range.
module rab_inv_range_cmp #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    input  logic [AW-1:0] va_start,
    input  logic [AW-1:0] va_end,
    output logic          hit
);
    assign hit = (lo <= va_end) && (hi >= va_start);
endmodule

// File: rtl/rab_inv_engine.sv
// rab_inv_engine: sweeps all L1 slices, then (with RAB_INV_L2_EN) every L2 entry,
// clearing those overlapping the requested VA range and counting the clears.
module rab_inv_engine
    import rab_inv_pkg::*;
#(
    parameter int AW = 32,
    parameter int N_SLICES = 32,
    parameter int L2_N_SETS = 32,
    parameter int L2_N_SET_ENTRIES = 32,
    parameter int PG_W = 12
) (
    input logic             Clk_CI,
    input logic             Rst_RBI,
    rab_inv_engine_if.slave bus
);
    localparam int L2_N = L2_N_SETS * L2_N_SET_ENTRIES;
    localparam int SW = idx_w(N_SLICES);
    localparam int CNT_W = cnt_w(N_SLICES, L2_N);
`ifdef RAB_INV_L2_EN
    localparam int KW = idx_w(L2_N);
    localparam state_e L1_NEXT = L2_RD;
`else
    localparam state_e L1_NEXT = DONE;
`endif
    state_e state_q, state_d;
    logic [AW-1:0] start_q, end_q;
    logic [SW-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, inv_cnt_q;
    logic l1_hit, l1_inv;
    rab_inv_range_cmp #(.AW(AW)) u_l1_cmp (
        .lo(bus.SliceFirst_DI[idx_q]),
        .hi(bus.SliceLast_DI[idx_q]),
        .va_start(start_q),
        .va_end(end_q),
        .hit(l1_hit)
    );
    assign l1_inv = (state_q == L1) && bus.SliceEn_DI[idx_q] && l1_hit;
    assign bus.SliceInv_SO = N_SLICES'(l1_inv) << idx_q;
    assign bus.ReqReady_SO = state_q == IDLE;
    assign bus.Busy_SO = state_q != IDLE;
    assign bus.CfgLock_SO = state_q != IDLE;
    assign bus.Done_SO = state_q == DONE;
    assign bus.InvCnt_DO = (state_q == DONE) ? cnt_q : inv_cnt_q;
`ifdef RAB_INV_L2_EN
    logic [KW-1:0] k_q, k_d;
    logic l2_hit, l2_clr;
    // A page end never carries: the offset bits are simply all ones, so no saturation is needed.
    rab_inv_range_cmp #(.AW(AW)) u_l2_cmp (
        .lo({bus.L2RdTag_DI, {PG_W{1'b0}}}),
        .hi({bus.L2RdTag_DI, {PG_W{1'b1}}}),
        .va_start(start_q),
        .va_end(end_q),
        .hit(l2_hit)
    );
    assign l2_clr = (state_q == L2_CHK) && bus.L2RdValid_DI && l2_hit;
    assign bus.L2Clr_SO = l2_clr;
    assign bus.L2Rd_SO = state_q == L2_RD;
    assign bus.L2Addr_DO = (state_q == L2_RD || state_q == L2_CHK) ? k_q : '0;
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) k_q <= '0;
        else k_q <= k_d;
    end
`else
    logic [AW-PG_W-1:0] unused_tag;
    logic unused_vld;
    assign unused_tag = bus.L2RdTag_DI;
    assign unused_vld = bus.L2RdValid_DI;
    assign bus.L2Clr_SO = 1'b0;
    assign bus.L2Rd_SO = 1'b0;
    assign bus.L2Addr_DO = '0;
`endif
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
`ifdef RAB_INV_L2_EN
        k_d = k_q;
`endif
        case (state_q)
            IDLE: if (bus.ReqValid_SI) begin
                state_d = (bus.ReqVaStart_DI > bus.ReqVaEnd_DI) ? DONE : L1;
                idx_d = '0;
                cnt_d = '0;
`ifdef RAB_INV_L2_EN
                k_d = '0;
`endif
            end
            L1: begin
                idx_d = idx_q + 1'b1;
                cnt_d = cnt_q + CNT_W'(l1_inv);
                state_d = (idx_q == SW'(N_SLICES - 1)) ? L1_NEXT : L1;
            end
`ifdef RAB_INV_L2_EN
            L2_RD: state_d = L2_CHK;
            L2_CHK: begin
                cnt_d = cnt_q + CNT_W'(l2_clr);
                state_d = (k_q == KW'(L2_N - 1)) ? DONE : L2_RD;
                k_d = (k_q == KW'(L2_N - 1)) ? k_q : k_q + 1'b1;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            inv_cnt_q <= '0;
            start_q <= '0;
            end_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            inv_cnt_q <= (state_q == DONE) ? cnt_q : inv_cnt_q;
            start_q <= (state_q == IDLE && bus.ReqValid_SI) ? bus.ReqVaStart_DI : start_q;
            end_q <= (state_q == IDLE && bus.ReqValid_SI) ? bus.ReqVaEnd_DI : end_q;
        end
    end
endmodule

// File: doc/rab_inv_engine.md
# rab_inv_engine

Parametrised range-invalidation engine for the RAB. Accepts an invalidation request `[VaStart, VaEnd]` over a valid/ready handshake, then sweeps every L1 slice of all ports and every L2 TLB entry, clearing those whose virtual range overlaps the request. It sits between the RAB config register file and the L1/L2 storage, replacing single-shot invalidation with a multi-port, range-based, counted operation. While active it locks configuration writes.

## Interface
- `AW`, 32: address width.
- `N_SLICES`, 32: total L1 slices over all ports, flattened in the order port 0 first.
- `L2_N_SETS`, 32: number of L2 sets.
- `L2_N_SET_ENTRIES`, 32: entries per set.
- `PG_W`, 12: page offset width; `VA_TAG_W = AW-PG_W`.

Ports:
- `Clk_CI` in 1: clock.
- `Rst_RBI` in 1: reset, asynchronous active-low.
- `ReqValid_SI` in 1, `ReqReady_SO` out 1: request handshake.
- `ReqVaStart_DI`, `ReqVaEnd_DI` in AW: inclusive range.
- `SliceFirst_DI`, `SliceLast_DI` in N_SLICES×AW: slice bounds.
- `SliceEn_DI` in N_SLICES: slice enable bits.
- `SliceInv_SO` out N_SLICES: one-cycle clear strobe per slice.
- `L2Addr_DO` out `$clog2(L2_N_SETS*L2_N_SET_ENTRIES)`: entry index, `set*L2_N_SET_ENTRIES+entry`.
- `L2Rd_SO` out 1: read strobe; data returns next cycle.
- `L2RdTag_DI` in VA_TAG_W, `L2RdValid_DI` in 1: read data.
- `L2Clr_SO` out 1: clear valid bit of `L2Addr_DO`.
- `Busy_SO` out 1, `CfgLock_SO` out 1 (equal to `Busy_SO`).
- `Done_SO` out 1: one-cycle completion pulse.
- `InvCnt_DO` out `CNT_W = $clog2(N_SLICES+L2_N_SETS*L2_N_SET_ENTRIES+1)`: entries cleared by last op.

## Operation
- FSM states: `IDLE`, `L1`, `L2_RD`, `L2_CHK`, `DONE`.
- `IDLE`: `ReqReady_SO=1`. On handshake, latch start and end, clear the counter, and set slice index 0.
  - If `start > end`, go to `DONE` directly.
  - Otherwise go to `L1`.
- `L1`: one slice per cycle, index `i`. If `SliceEn_DI[i] && SliceFirst_DI[i] <= end && SliceLast_DI[i] >= start`, pulse `SliceInv_SO[i]` and increment the counter. After `i = N_SLICES-1`, go to `L2_RD`, or to `DONE` if L2 support is compiled out.
- `L2_RD`: drive `L2Addr_DO = k` and `L2Rd_SO=1`, then go to `L2_CHK`.
- `L2_CHK`: page VA = `{L2RdTag_DI, PG_W'0}`.
  - If `L2RdValid_DI` and page VA ≤ end and page VA + 2^PG_W − 1 ≥ start, pulse `L2Clr_SO` with `L2Addr_DO = k` and increment the counter.
  - If `k` is the last entry, go to `DONE`; otherwise increment `k` and go to `L2_RD`.
- `DONE`: pulse `Done_SO`, load `InvCnt_DO`, go to `IDLE`.
- Compares are unsigned, full AW. A page-end sum that exceeds AW saturates to all-ones, with no wrap.
- `InvCnt_DO` holds its value until the next `DONE`.
- Requests arriving while busy stall on ready; none are dropped.

## Timing
- Handshake edge is cycle 0.
- L1 strobe for slice `i` occurs in cycle `i+1`.
- `Done_SO` occurs in cycle `N_SLICES + 2·L2_N_SETS·L2_N_SET_ENTRIES + 1`. With L2 compiled out, it occurs in cycle `N_SLICES+1`. For a degenerate range, it occurs in cycle 1.
- `Busy_SO` is high from cycle 1 through the `DONE` cycle inclusive. `ReqReady_SO` returns high in the cycle after `DONE`.
- Back-to-back requests: the next handshake is possible in the cycle after `DONE`.
- Reset values: `ReqReady_SO=1`; all strobes 0; `Busy_SO`, `CfgLock_SO`, `Done_SO` 0; `InvCnt_DO=0`; `L2Addr_DO=0`.
- Reset mid-sweep returns to `IDLE` immediately. No further strobes are issued and partial clears are not rolled back.

## Configuration
- `RAB_INV_L2_EN` defined: `L2_RD`/`L2_CHK` states, L2 ports and the L2 counter contribution are present.
- Not defined: L2 ports tie off (`L2Rd_SO=0`, `L2Clr_SO=0`, `L2Addr_DO=0`), inputs are ignored, and the FSM goes `L1 → DONE`. `CNT_W` uses `N_SLICES` only.

## Structure
- `rab_inv_pkg`: FSM state enum and `CNT_W`/index-width functions.
- Sub-module `rab_inv_range_cmp`: combinational overlap check of `[lo, hi]` against the latched range. It is instanced once for L1 and once for L2.

## Test plan
Configuration for all tests: `N_SLICES=8`, 32 sets × 1 entry, 4 KiB pages.

- **Full range:** all slices enabled, slice `i` at VA `0x20000+i·0x1000`, all L2 valid; request `[0, 0xFFFFFFFF]` → 8 slice strobes, 32 `L2Clr_SO`, `InvCnt_DO=40`, `Done_SO` at cycle 73.
- **Partial range:** request `[0x21000, 0x22FFF]` → strobes on slices 1 and 2 only, `InvCnt_DO=2`.
- **Disabled and invalid entries:** slice 3 disabled and L2 entry 5 invalid, both inside the range → no strobe for either, and the count excludes both.
- **Degenerate range:** request `start=0x5000, end=0x4000` → `Done_SO` at cycle 1, `InvCnt_DO=0`, no strobes.
- **Back-to-back requests:** hold `ReqValid_SI` during a sweep → `ReqReady_SO=0` and `CfgLock_SO=1` until `DONE`; the second request is accepted the cycle after.
- **Reset mid-sweep:** assert `Rst_RBI` at cycle 4 → all outputs return to reset values and no strobes follow. Rerun with `RAB_INV_L2_EN` undefined → `Done_SO` at cycle 9.
